// File: rtl/frogger_pkg.sv
// Shared constants and types for the frogger collision logic.
package frogger_pkg;

  localparam int unsigned SCREEN_W    = 320;
  // Car x at or beyond this value has wrapped below zero and is not drawn.
  localparam int unsigned OFFSCREEN_X = 400;
  localparam int unsigned LIVES_W     = 3;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StScan    = 2'd1,
    StRespawn = 2'd2,
    StOver    = 2'd3
  } state_e;

endpackage

// File: rtl/frog_collision_checker_if.sv
// Bundles car/frog inputs and collision status outputs of the checker.
interface frog_collision_checker_if #(
  parameter int unsigned NUM_CARS = 8
);
  import frogger_pkg::*;

  logic [9*NUM_CARS-1:0] car_x;
  logic [8*NUM_CARS-1:0] car_y;
  logic [NUM_CARS-1:0]   car_move;
  logic [8:0]            frog_x;
  logic [7:0]            frog_y;
  logic                  frog_move;
  logic                  respawn_ack;
  logic                  game_restart;
  logic                  hit;
  logic                  frog_respawn;
  logic [LIVES_W-1:0]    lives;
  logic                  game_over;
  logic                  busy;

  modport master (
    output car_x, car_y, car_move, frog_x, frog_y, frog_move, respawn_ack, game_restart,
    input  hit, frog_respawn, lives, game_over, busy
  );

  modport slave (
    input  car_x, car_y, car_move, frog_x, frog_y, frog_move, respawn_ack, game_restart,
    output hit, frog_respawn, lives, game_over, busy
  );

endinterface

// File: rtl/rect_overlap.sv
// Combinational strict rectangle overlap; rectangle A is a car and obeys the off-screen rule.
module rect_overlap
  import frogger_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned AH = 10,
  parameter int unsigned BW = 10,
  parameter int unsigned BH = 10
) (
  input  logic [8:0] a_x_i,
  input  logic [7:0] a_y_i,
  input  logic [8:0] b_x_i,
  input  logic [7:0] b_y_i,
  output logic       overlap_o
);

  logic [9:0] a_x_ext, b_x_ext, a_right, b_right;
  logic [8:0] a_y_ext, b_y_ext, a_bottom, b_bottom;
  logic       a_offscreen;

  // One extra bit keeps right/bottom edges from wrapping.
  always_comb begin
    a_x_ext     = {1'b0, a_x_i};
    b_x_ext     = {1'b0, b_x_i};
    a_y_ext     = {1'b0, a_y_i};
    b_y_ext     = {1'b0, b_y_i};
    a_right     = a_x_ext + 10'(AW);
    b_right     = b_x_ext + 10'(BW);
    a_bottom    = a_y_ext + 9'(AH);
    b_bottom    = b_y_ext + 9'(BH);
    a_offscreen = (a_x_ext >= 10'(OFFSCREEN_X));
    overlap_o   = !a_offscreen &&
                  (a_x_ext < b_right) && (b_x_ext < a_right) &&
                  (a_y_ext < b_bottom) && (b_y_ext < a_bottom);
  end

endmodule

// File: rtl/frog_collision_checker.sv
// Scans one car per cycle against the frog after any movement and tracks lives/respawn.
module frog_collision_checker
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_CARS   = 8,
  parameter int unsigned CAR_W      = 16,
  parameter int unsigned CAR_H      = 10,
  parameter int unsigned FROG_W     = 10,
  parameter int unsigned FROG_H     = 10,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  frog_collision_checker_if.slave  bus
);

  localparam logic [IDX_W-1:0]   LastIdx   = IDX_W'(NUM_CARS - 1);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               hit_q, hit_d;
  logic               frog_respawn_q, frog_respawn_d;
  logic               game_over_q, game_over_d;

  logic       trigger;
  logic [8:0] sel_x;
  logic [7:0] sel_y;
  logic       overlap;

  // Select the car under test; inputs are live, never latched.
  always_comb begin
    trigger = bus.frog_move | (|bus.car_move);
    sel_x   = bus.car_x[9*idx_q +: 9];
    sel_y   = bus.car_y[8*idx_q +: 8];
  end

  rect_overlap #(
    .AW(CAR_W),
    .AH(CAR_H),
    .BW(FROG_W),
    .BH(FROG_H)
  ) u_rect_overlap (
    .a_x_i    (sel_x),
    .a_y_i    (sel_y),
    .b_x_i    (bus.frog_x),
    .b_y_i    (bus.frog_y),
    .overlap_o(overlap)
  );

  // Next-state logic for scan sequencing, lives and respawn handshake.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    lives_d        = lives_q;
    hit_d          = 1'b0;
    frog_respawn_d = frog_respawn_q;
    game_over_d    = game_over_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d   = StScan;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      StScan: begin
        if (overlap) begin
          hit_d     = 1'b1;
          pending_d = 1'b0;
          if (lives_q > LIVES_W'(1)) begin
            lives_d        = lives_q - LIVES_W'(1);
            frog_respawn_d = 1'b1;
            state_d        = StRespawn;
          end else begin
            lives_d        = '0;
            game_over_d    = 1'b1;
            frog_respawn_d = 1'b0;
            state_d        = StOver;
          end
        end else if (idx_q != LastIdx) begin
          idx_d = idx_q + IDX_W'(1);
          if (trigger) pending_d = 1'b1;
        end else if (pending_q || trigger) begin
          // Something moved during this pass; rescan from the first car.
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StRespawn: begin
        pending_d = 1'b0;
        if (bus.respawn_ack) begin
          frog_respawn_d = 1'b0;
          state_d        = StIdle;
        end
      end
      StOver: begin
        if (bus.game_restart) begin
          lives_d     = LivesInit;
          game_over_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      lives_q        <= LivesInit;
      hit_q          <= 1'b0;
      frog_respawn_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      lives_q        <= lives_d;
      hit_q          <= hit_d;
      frog_respawn_q <= frog_respawn_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.hit          = hit_q;
  assign bus.frog_respawn = frog_respawn_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = game_over_q;
  assign bus.busy         = (state_q == StScan);

endmodule

// File: tb/tb_frog_collision_checker.sv
// Directed plus randomized bench for frog_collision_checker against a behavioural model.
module tb_frog_collision_checker;

  localparam int N = 8;
  localparam int MIdle = 0, MScan = 1, MResp = 2, MOver = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frog_collision_checker_if #(.NUM_CARS(N)) bus ();

  frog_collision_checker #(
    .NUM_CARS  (N),
    .CAR_W     (16),
    .CAR_H     (10),
    .FROG_W    (10),
    .FROG_H    (10),
    .LIVES_INIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus state
  int cx[N];
  int cy[N];
  int fx, fy;
  bit [N-1:0] mv;
  bit fm, ack, rs;

  // Model state
  int m_mode, m_idx, m_pend, m_lives, m_hit, m_resp, m_over;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Two rectangles overlap when the intersection of their spans is non-empty on both axes.
  function automatic int collide(int ax, int ay, int bx, int by);
    if (ax >= 400) return 0;
    return ((imax(ax, bx) < imin(ax + 16, bx + 10)) &&
            (imax(ay, by) < imin(ay + 10, by + 10))) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.car_x[9*i +: 9] = 9'(cx[i]);
      bus.car_y[8*i +: 8] = 8'(cy[i]);
    end
    bus.car_move     = mv;
    bus.frog_x       = 9'(fx);
    bus.frog_y       = 8'(fy);
    bus.frog_move    = fm;
    bus.respawn_ack  = ack;
    bus.game_restart = rs;
  endtask

  task automatic model_step();
    int trig;
    trig  = (fm || (mv != 0)) ? 1 : 0;
    m_hit = 0;
    if (rst) begin
      m_mode = MIdle; m_idx = 0; m_pend = 0; m_lives = 3; m_resp = 0; m_over = 0;
    end else begin
      case (m_mode)
        MIdle: if (trig != 0) begin m_mode = MScan; m_idx = 0; m_pend = 0; end
        MScan: begin
          if (collide(cx[m_idx], cy[m_idx], fx, fy) != 0) begin
            m_hit = 1; m_pend = 0;
            if (m_lives > 1) begin m_lives--; m_resp = 1; m_mode = MResp; end
            else begin m_lives = 0; m_over = 1; m_resp = 0; m_mode = MOver; end
          end else if (m_idx < N - 1) begin
            m_idx++;
            if (trig != 0) m_pend = 1;
          end else if (m_pend != 0 || trig != 0) begin
            m_idx = 0; m_pend = 0;
          end else begin
            m_mode = MIdle;
          end
        end
        MResp: begin
          m_pend = 0;
          if (ack) begin m_resp = 0; m_mode = MIdle; end
        end
        default: if (rs) begin m_lives = 3; m_over = 0; m_mode = MIdle; end
      endcase
    end
  endtask

  // One clock: apply inputs, advance model, compare all outputs just after the edge.
  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
    chk("hit", bus.hit, m_hit);
    chk("respawn", bus.frog_respawn, m_resp);
    chk("lives", bus.lives, m_lives);
    chk("over", bus.game_over, m_over);
    chk("busy", bus.busy, (m_mode == MScan) ? 1 : 0);
  endtask

  initial begin
    int n, nbusy, seen, j;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin cx[i] = 450; cy[i] = 0; end
    fx = 200; fy = 200; mv = '0; fm = 0; ack = 0; rs = 0;
    cycle();
    cycle();
    chk("rst_lives", bus.lives, 3);
    chk("rst_hit", bus.hit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_over", bus.game_over, 0);
    rst = 1'b0;
    cycle();

    // Basic hit: pulse two cycles after trigger.
    cx[0] = 100; cy[0] = 50; fx = 110; fy = 55;
    fm = 1; cycle(); fm = 0;
    chk("t1_hit_early", bus.hit, 0);
    cycle();
    chk("t1_hit", bus.hit, 1);
    chk("t1_lives", bus.lives, 2);
    chk("t1_resp", bus.frog_respawn, 1);
    repeat (3) cycle();
    fm = 1; cycle(); fm = 0;
    chk("t1_resp_hold", bus.frog_respawn, 1);
    chk("t1_ignore_trig", bus.busy, 0);
    ack = 1; fm = 1; cycle(); ack = 0; fm = 0;
    chk("t1_resp_clr", bus.frog_respawn, 0);
    cycle();
    chk("t1_drop_trig", bus.busy, 0);
    rs = 1; cycle(); rs = 0;
    chk("t1_restart_ign", bus.lives, 2);

    // Edge touching on x: full scan, no hit.
    fx = 116; fy = 55;
    nbusy = 0; seen = 0;
    fm = 1;
    for (int i = 0; i < 20; i++) begin
      cycle(); fm = 0;
      if (bus.busy === 1'b1) nbusy++;
      if (bus.hit === 1'b1) seen = 1;
    end
    chk("t2_busy_cycles", nbusy, 8);
    chk("t2_no_hit", seen, 0);

    // Off-screen cars never hit; 399 is still on-screen.
    cx[0] = 450; cx[3] = 460; cy[3] = 50; fx = 0; fy = 50;
    seen = 0; fm = 1;
    for (int i = 0; i < 12; i++) begin cycle(); fm = 0; if (bus.hit === 1'b1) seen = 1; end
    chk("t3_wrap_nohit", seen, 0);
    cx[3] = 400; fx = 395;
    seen = 0; fm = 1;
    for (int i = 0; i < 12; i++) begin cycle(); fm = 0; if (bus.hit === 1'b1) seen = 1; end
    chk("t3_x400_nohit", seen, 0);
    cx[3] = 399;
    seen = 0; fm = 1;
    for (int i = 0; i < 12; i++) begin cycle(); fm = 0; if (bus.hit === 1'b1) seen = 1; end
    chk("t3_x399_hit", seen, 1);
    chk("t3_lives", bus.lives, 1);
    ack = 1; cycle(); ack = 0;

    // Last life: game over, then restart.
    seen = 0; fm = 1;
    for (int i = 0; i < 12; i++) begin cycle(); fm = 0; if (bus.hit === 1'b1) seen = 1; end
    chk("t4_hit", seen, 1);
    chk("t4_lives", bus.lives, 0);
    chk("t4_over", bus.game_over, 1);
    chk("t4_resp", bus.frog_respawn, 0);
    fm = 1; ack = 1; repeat (4) cycle(); fm = 0; ack = 0;
    chk("t4_ignore", bus.busy, 0);
    chk("t4_still_over", bus.game_over, 1);
    rs = 1; cycle(); rs = 0;
    chk("t4_restart_lives", bus.lives, 3);
    chk("t4_restart_over", bus.game_over, 0);
    cx[3] = 450;
    cycle();

    // Pending rescan: car5 moves at idx 2, car7 lands on frog after first pass.
    fx = 200; fy = 200;
    fm = 1; cycle(); fm = 0;
    cycle(); cycle();
    mv[5] = 1; cycle(); mv = '0;
    repeat (5) cycle();
    chk("t5_rescan_busy", bus.busy, 1);
    cx[7] = 195; cy[7] = 195; mv[7] = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(); mv = '0; n++;
      if (bus.hit === 1'b1) break;
    end
    chk("t5_hit_lat", n, 8);
    chk("t5_lives", bus.lives, 2);
    ack = 1; cycle(); ack = 0;
    cx[7] = 450;

    // Reset mid-scan with a hit pending at idx 5.
    cx[5] = 200; cy[5] = 200;
    fm = 1; cycle(); fm = 0;
    repeat (4) cycle();
    rst = 1; cycle(); rst = 0;
    chk("t6_hit", bus.hit, 0);
    chk("t6_lives", bus.lives, 3);
    chk("t6_busy", bus.busy, 0);
    chk("t6_resp", bus.frog_respawn, 0);
    repeat (3) cycle();
    cx[5] = 450;

    // Randomized traffic around the frog.
    fx = 120; fy = 60;
    for (int i = 0; i < 600; i++) begin
      fm  = ($urandom_range(0, 5) == 0);
      mv  = N'($urandom & $urandom & $urandom);
      ack = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, N - 1);
        cx[j] = ($urandom_range(0, 7) == 0) ? $urandom_range(400, 511) : $urandom_range(80, 170);
        cy[j] = $urandom_range(30, 90);
      end
      if ($urandom_range(0, 15) == 0) begin
        fx = $urandom_range(90, 150);
        fy = $urandom_range(40, 80);
      end
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
